// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master between NUM_REQ byte-burst requesters.
// Grant and link configuration are frozen from the first byte until the master has drained back to idle.
module spi_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATAWIDTH = 8,
    parameter int IDXW      = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           resetN,
    input  logic [NUM_REQ-1:0]             reqValid,
    input  logic [NUM_REQ*DATAWIDTH-1:0]   reqData,
    input  logic [NUM_REQ-1:0]             reqLast,
    output logic [NUM_REQ-1:0]             reqReady,
    output logic [NUM_REQ-1:0]             rspValid,
    output logic [DATAWIDTH-1:0]           rspData,
    input  logic [NUM_REQ*16-1:0]          cfgClocksPerCycle,
    input  logic [NUM_REQ-1:0]             cfgPolarity,
    input  logic [NUM_REQ-1:0]             cfgPhase,
    input  logic [NUM_REQ-1:0]             cfgDirection,
    input  logic [NUM_REQ-1:0]             cfgSsEnable,
    output logic [IDXW-1:0]                grantIdx,
    output logic                           busy,
    output logic [15:0]                    spiClocksPerCycle,
    output logic                           spiClockPolarity,
    output logic                           spiClockPhase,
    output logic                           spiDataDirection,
    output logic                           spiSsEnable,
    output logic                           spiTransmitValid,
    output logic [DATAWIDTH-1:0]           spiDataRegIn,
    input  logic                           spiTransmitReady,
    input  logic                           spiReceiveValid,
    input  logic [DATAWIDTH-1:0]           spiDataReg,
    input  logic                           spiSs,
    output logic [NUM_REQ-1:0]             ssN
);

    typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_e;

    state_e          state_q;
    logic [IDXW-1:0] grant_q;
    logic [IDXW-1:0] rr_ptr_q;
    logic            last_acc_q;
    logic [17:0]     drain_cnt_q;
    logic [15:0]     cpc_q;
    logic            pol_q, pha_q, dir_q, sse_q;

    logic [IDXW-1:0] pick_idx;
    logic            pick_vld;
    logic [IDXW-1:0] grant_nxt;
    logic            in_xfer, tx_vld, accept, end_burst;

    // Descending scan so the smallest cyclic offset from rr_ptr_q wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            if (reqValid[IDXW'((int'(rr_ptr_q) + off) % NUM_REQ)]) begin
                pick_vld = 1'b1;
                pick_idx = IDXW'((int'(rr_ptr_q) + off) % NUM_REQ);
            end
        end
    end

    assign grant_nxt = (grant_q == IDXW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
    assign in_xfer   = (state_q == XFER);
    assign tx_vld    = in_xfer && reqValid[grant_q] && !last_acc_q;
    assign accept    = tx_vld && spiTransmitReady;
    // A receive with nothing queued behind it closes the burst, whether reqLast was seen or the requester underran.
    assign end_burst = in_xfer && spiReceiveValid && (last_acc_q || !tx_vld);

    assign busy              = (state_q != IDLE);
    assign grantIdx          = grant_q;
    assign spiTransmitValid  = tx_vld;
    assign spiDataRegIn      = reqData[grant_q*DATAWIDTH +: DATAWIDTH];
    assign rspData           = spiDataReg;
    assign spiClocksPerCycle = cpc_q;
    assign spiClockPolarity  = pol_q;
    assign spiClockPhase     = pha_q;
    assign spiDataDirection  = dir_q;
    assign spiSsEnable       = sse_q;

    always_comb begin
        reqReady          = '0;
        rspValid          = '0;
        ssN               = '1;
        reqReady[grant_q] = in_xfer && spiTransmitReady && !last_acc_q;
        rspValid[grant_q] = in_xfer && spiReceiveValid;
        ssN[grant_q]      = busy ? spiSs : 1'b1;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            last_acc_q  <= 1'b0;
            drain_cnt_q <= '0;
            cpc_q       <= 16'd1;
            pol_q       <= 1'b0;
            pha_q       <= 1'b0;
            dir_q       <= 1'b0;
            sse_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        grant_q    <= pick_idx;
                        cpc_q      <= cfgClocksPerCycle[pick_idx*16 +: 16];
                        pol_q      <= cfgPolarity[pick_idx];
                        pha_q      <= cfgPhase[pick_idx];
                        dir_q      <= cfgDirection[pick_idx];
                        sse_q      <= cfgSsEnable[pick_idx];
                        last_acc_q <= 1'b0;
                        state_q    <= XFER;
                    end
                end
                XFER: begin
                    if (accept && reqLast[grant_q]) begin
                        last_acc_q <= 1'b1;
                    end
                    if (end_burst) begin
                        drain_cnt_q <= {1'b0, cpc_q, 1'b0} + 18'd4;
                        state_q     <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Counter reaches zero on the edge that returns to IDLE: exactly 2*cpc+4 drain cycles.
                    drain_cnt_q <= drain_cnt_q - 18'd1;
                    if (drain_cnt_q <= 18'd1) begin
                        rr_ptr_q <= grant_nxt;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed and randomized bench for spi_arbiter with a loopback SPI-master model and a burst-level reference.
module tb_spi_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic [N-1:0] reqValid, reqLast, reqReady, rspValid, ssN;
    logic [N-1:0] cfgPolarity, cfgPhase, cfgDirection, cfgSsEnable;
    logic [N*W-1:0] reqData;
    logic [N*16-1:0] cfgClocksPerCycle;
    logic [W-1:0] rspData, spiDataRegIn, spiDataReg;
    logic [1:0] grantIdx;
    logic busy;
    logic [15:0] spiClocksPerCycle;
    logic spiClockPolarity, spiClockPhase, spiDataDirection, spiSsEnable;
    logic spiTransmitValid, spiTransmitReady, spiReceiveValid, spiSs;

    always #5 clk = ~clk;

    spi_arbiter #(.NUM_REQ(N), .DATAWIDTH(W)) dut (
        .clk(clk), .resetN(resetN),
        .reqValid(reqValid), .reqData(reqData), .reqLast(reqLast), .reqReady(reqReady),
        .rspValid(rspValid), .rspData(rspData),
        .cfgClocksPerCycle(cfgClocksPerCycle), .cfgPolarity(cfgPolarity), .cfgPhase(cfgPhase),
        .cfgDirection(cfgDirection), .cfgSsEnable(cfgSsEnable),
        .grantIdx(grantIdx), .busy(busy),
        .spiClocksPerCycle(spiClocksPerCycle), .spiClockPolarity(spiClockPolarity),
        .spiClockPhase(spiClockPhase), .spiDataDirection(spiDataDirection), .spiSsEnable(spiSsEnable),
        .spiTransmitValid(spiTransmitValid), .spiDataRegIn(spiDataRegIn),
        .spiTransmitReady(spiTransmitReady), .spiReceiveValid(spiReceiveValid),
        .spiDataReg(spiDataReg), .spiSs(spiSs), .ssN(ssN)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // requester bursts
    logic [W-1:0] txb [N][8];
    int tx_len [N];
    int tx_pos [N];
    int rx_pos [N];
    bit nolast [N];
    logic [15:0] cpc [N];
    logic [N-1:0] pol, pha, dir, sse;

    // loopback SPI master: echoes each accepted byte after a random delay
    bit u_busy = 0;
    int u_cnt = 0;
    logic [W-1:0] u_byte = '0;

    // burst-level reference
    int m_rr = 0, m_grant = 0, exp_grant = 0, last_rsp_cyc = 0, bursts = 0;
    bit prev_busy = 0, gap = 0;
    logic [15:0] cap_cpc = '0;
    logic [3:0] cap_mode = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            reqValid[i] = tx_pos[i] < tx_len[i];
            reqData[i*W +: W] = txb[i][tx_pos[i] & 7];
            reqLast[i] = reqValid[i] && (tx_pos[i] == tx_len[i] - 1) && !nolast[i];
            cfgClocksPerCycle[i*16 +: 16] = cpc[i];
        end
        cfgPolarity = pol; cfgPhase = pha; cfgDirection = dir; cfgSsEnable = sse;
        spiTransmitReady = !u_busy || u_cnt == 0;
        spiReceiveValid  = u_busy && u_cnt == 0;
        spiDataReg       = u_byte;
        spiSs            = !u_busy;
    endtask

    task automatic load(input int r, input int len, input bit nl);
        for (int k = 0; k < len; k++) txb[r][k] = W'($urandom);
        tx_len[r] = len; tx_pos[r] = 0; rx_pos[r] = 0; nolast[r] = nl;
        drive();
    endtask

    task automatic cfg_rand();
        for (int i = 0; i < N; i++) cpc[i] = 16'($urandom_range(1, 6));
        pol = N'($urandom); pha = N'($urandom); dir = N'($urandom); sse = N'($urandom);
    endtask

    task automatic monitor();
        logic [N-1:0] own, exp_ss, hs;
        if (prev_busy && !busy) begin
            check("drain_len", cyc - last_rsp_cyc - 1, 2 * cap_cpc + 4);
            check("rsp_count", rx_pos[m_grant], tx_len[m_grant]);
            check("cfg_frozen", {spiClocksPerCycle, spiClockPolarity, spiClockPhase, spiDataDirection, spiSsEnable},
                  {cap_cpc, cap_mode});
            check("grant_held", grantIdx, m_grant);
            check("no_tx_gap", gap, 0);
            m_rr = (m_grant + 1) % N;
        end
        if (!prev_busy && busy) begin
            check("grantIdx", grantIdx, exp_grant);
            check("cfg_start", {spiClocksPerCycle, spiClockPolarity, spiClockPhase, spiDataDirection, spiSsEnable},
                  {cap_cpc, cap_mode});
            m_grant = exp_grant; gap = 0; bursts++;
        end
        own = '0; exp_ss = '1;
        if (busy) begin own[m_grant] = 1'b1; exp_ss[m_grant] = spiSs; end
        check("ssN", ssN, exp_ss);
        check("reqReady_owner", reqReady & ~own, 0);
        hs = (spiTransmitValid && spiTransmitReady) ? own : '0;
        check("handshake", reqValid & reqReady, hs);
        if (spiTransmitValid) check("tx_data", spiDataRegIn, txb[m_grant][tx_pos[m_grant] & 7]);
        if (rspValid != 0) begin
            check("rspValid_owner", rspValid, own);
            check("rspData", rspData, txb[m_grant][rx_pos[m_grant] & 7]);
            rx_pos[m_grant]++;
            last_rsp_cyc = cyc;
        end
        if (busy && !nolast[m_grant] && tx_pos[m_grant] > 0 && tx_pos[m_grant] < tx_len[m_grant] && !spiTransmitValid)
            gap = 1;
        if (!busy && reqValid != 0) begin
            for (int k = N - 1; k >= 0; k--) if (reqValid[(m_rr + k) % N]) exp_grant = (m_rr + k) % N;
            cap_cpc  = cpc[exp_grant];
            cap_mode = {pol[exp_grant], pha[exp_grant], dir[exp_grant], sse[exp_grant]};
        end
        prev_busy = busy;
    endtask

    task automatic tick();
        logic [N-1:0] acc;
        bit u_acc;
        logic [W-1:0] u_din;
        @(negedge clk);
        cyc++;
        acc = reqValid & reqReady;
        u_acc = spiTransmitValid && spiTransmitReady;
        u_din = spiDataRegIn;
        if (resetN) monitor();
        @(posedge clk);
        #1;
        if (!resetN) begin
            u_busy = 0;
        end else begin
            if (u_busy && u_cnt == 0) u_busy = 0;
            else if (u_busy) u_cnt--;
            if (u_acc) begin u_busy = 1; u_cnt = $urandom_range(1, 4); u_byte = u_din; end
            for (int i = 0; i < N; i++) if (acc[i]) tx_pos[i]++;
        end
        drive();
    endtask

    task automatic run_quiet(input int budget, input bit jitter);
        int n = 0;
        bit pend;
        do begin
            tick(); n++;
            if (jitter && $urandom_range(0, 5) == 0) begin cfg_rand(); drive(); end
            pend = 0;
            for (int i = 0; i < N; i++) if (tx_pos[i] < tx_len[i]) pend = 1;
        end while ((pend || busy) && n < budget);
        check("quiet", {pend, busy}, 2'b00);
        tick();
    endtask

    task automatic check_reset_vals();
        check("rst_reqReady", reqReady, 0);
        check("rst_rspValid", rspValid, 0);
        check("rst_txValid", spiTransmitValid, 0);
        check("rst_ssN", ssN, 4'hF);
        check("rst_busy", busy, 0);
        check("rst_grant", grantIdx, 0);
        check("rst_cpc", spiClocksPerCycle, 16'd1);
        check("rst_mode", {spiClockPolarity, spiClockPhase, spiDataDirection, spiSsEnable}, 0);
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin tx_len[i] = 0; tx_pos[i] = 0; rx_pos[i] = 0; nolast[i] = 0; end
        u_busy = 0; u_cnt = 0; m_rr = 0; m_grant = 0; prev_busy = 0; gap = 0;
        drive();
    endtask

    initial begin
        int n, b0;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 8; k++) txb[i][k] = '0;
            cpc[i] = 16'd3;
        end
        pol = '0; pha = '0; dir = '0; sse = '1;
        clear_model();

        // reset state
        tick(); tick();
        check_reset_vals();
        resetN = 1'b1;
        tick();

        // round-robin: 0 and 3 together, then 0 alone (rr=1), then 1 beats 3
        load(0, 1, 0); load(3, 1, 0);
        run_quiet(500, 0);
        load(0, 1, 0);
        run_quiet(500, 0);
        load(1, 1, 0); load(3, 1, 0);
        run_quiet(500, 0);

        // config isolation: req0 pol0 cpc2 first, req1 pol1 cpc8; the active owner's cfg is changed mid-burst
        cpc[0] = 16'd2; pol[0] = 1'b0; cpc[1] = 16'd8; pol[1] = 1'b1;
        load(0, 2, 0); load(1, 2, 0);
        repeat (3) tick();
        pol[m_grant] = ~pol[m_grant]; cpc[m_grant] = cpc[m_grant] + 16'd3; drive();
        run_quiet(1000, 0);

        // single burst on requester 2
        cpc[2] = 16'd4; pha[2] = 1'b0; dir[2] = 1'b1;
        load(2, 2, 0); txb[2][0] = 8'hA5; txb[2][1] = 8'h3C; drive();
        run_quiet(500, 0);

        // underrun: one byte without reqLast, then valid drops
        load(1, 1, 1); txb[1][0] = 8'h11; drive();
        run_quiet(500, 0);

        // back-to-back 3-byte burst with valid held
        load(3, 3, 0);
        run_quiet(500, 0);

        // randomized traffic with config churn
        for (int it = 0; it < 25; it++) begin
            logic [N-1:0] mask;
            cfg_rand();
            mask = N'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) if (mask[i]) load(i, $urandom_range(1, 4), 0);
            run_quiet(3000, 1);
        end

        // reset mid-burst during the second byte
        load(2, 3, 0);
        n = 0;
        while (tx_pos[2] < 2 && n < 200) begin tick(); n++; end
        check("reached_second_byte", tx_pos[2], 2);
        #2 resetN = 1'b0;
        #1 check_reset_vals();
        clear_model();
        tick(); tick();
        check_reset_vals();
        resetN = 1'b1;
        b0 = bursts;
        load(1, 2, 0);
        run_quiet(500, 0);
        check("post_reset_burst", bursts, b0 + 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
